ds_tx_encoder: RTL

IEEE1355 DS-link character transmitter that sits directly upstream of the node's `d_outA`/`s_outA` pads. It accepts 9-bit N-chars (a data byte or an EOP) from the transmit FIFO over a valid/ready handshake. It inserts FCT characters on request and sends NULLs when idle. It serialises characters with link parity onto Data/Strobe lines, gated by received-FCT flow-control credit.

---
 rtl/ds_tx_encoder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ds_tx_encoder.sv
// IEEE1355 DS-link character transmitter: FCT/N-char/NULL selection, link parity, DS serialisation, credit.
// Optional DS_TX_PARITY_ERR_INJECT_EN adds inject_parity_err to corrupt the P bit of one chosen character.
module ds_tx_encoder #(
  parameter int G_CLK_DIV            = 2,
  parameter bit G_LINK_PARITY_IS_ODD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [8:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       fct_req,
  output logic       fct_ack,
  input  logic       fct_rx,
  output logic [5:0] credit,
  output logic       credit_err,
`ifdef DS_TX_PARITY_ERR_INJECT_EN
  input  logic       inject_parity_err,
`endif
  output logic       d_out,
  output logic       s_out
);

  localparam int             DIV_W    = (G_CLK_DIV > 1) ? $clog2(G_CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(G_CLK_DIV - 1);
  localparam logic           ODD      = G_LINK_PARITY_IS_ODD;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_SHIFT} state_t;

  state_t           state_q;
  logic [9:0]       sh_q;
  logic [3:0]       bits_q;
  logic [DIV_W-1:0] div_q;
  logic             d_q, s_q, par_acc_q, fct_pend_q, credit_err_q;
  logic [5:0]       credit_q;

  logic [9:0]       char_vec;
  logic [3:0]       char_last;
  logic             char_acc, inject, accept;
  logic [DIV_W-1:0] div_inc;

`ifdef DS_TX_PARITY_ERR_INJECT_EN
  assign inject = inject_parity_err;
`else
  assign inject = 1'b0;
`endif

  assign tx_ready   = (state_q == S_SELECT) && enable && !fct_pend_q && (credit_q != 6'd0);
  assign fct_ack    = (state_q == S_SELECT) && enable && fct_pend_q;
  assign accept     = tx_valid && tx_ready;
  assign credit     = credit_q;
  assign credit_err = credit_err_q;
  assign d_out      = d_q;
  assign s_out      = s_q;
  assign div_inc    = div_q + DIV_W'(1);

  // Character picked at SELECT, wire order from bit 0; a NULL is ESC+FCT loaded as one 8-bit unit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    char_vec  = '0;
    char_last = 4'd3;
    char_acc  = 1'b0;
    if (fct_pend_q) begin
      char_vec[3:0] = {1'b0, 1'b0, 1'b1, 1'b1 ^ par_acc_q ^ ODD};
    end else if (tx_valid && (credit_q != 6'd0)) begin
      if (!tx_data[8]) begin
        char_vec  = {tx_data[7:0], 1'b0, par_acc_q ^ ODD};
        char_last = 4'd9;
        char_acc  = ^tx_data[7:0];
      end else begin
        char_vec[3:0] = {tx_data[0], ~tx_data[0], 1'b1, 1'b1 ^ par_acc_q ^ ODD};
        char_acc      = 1'b1;
      end
    end else begin
      char_vec[7:0] = {1'b0, 1'b0, 1'b1, 1'b1 ^ ODD, 1'b1, 1'b1, 1'b1, 1'b1 ^ par_acc_q ^ ODD};
      char_last     = 4'd7;
    end
    char_vec[0] = char_vec[0] ^ inject;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sh_q         <= '0;
      bits_q       <= '0;
      div_q        <= '0;
      d_q          <= 1'b0;
      s_q          <= 1'b0;
      par_acc_q    <= 1'b0;
      fct_pend_q   <= 1'b0;
      credit_q     <= '0;
      credit_err_q <= 1'b0;
    end else begin
      credit_err_q <= fct_rx && (credit_q > 6'd48);
      if (!enable)                              credit_q <= '0;
      else if (fct_rx && (credit_q <= 6'd48))  credit_q <= credit_q + (accept ? 6'd7 : 6'd8);
      else if (accept)                          credit_q <= credit_q - 6'd1;

      if (fct_ack)      fct_pend_q <= 1'b0;
      else if (fct_req) fct_pend_q <= 1'b1;

      if (!enable) par_acc_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          d_q <= 1'b0;
          s_q <= 1'b0;
          if (enable) state_q <= S_SELECT;
        end
        S_SELECT: begin
          if (!enable) begin
            state_q <= S_IDLE;
            d_q     <= 1'b0;
            s_q     <= 1'b0;
          end else begin
            d_q       <= char_vec[0];
            s_q       <= s_q ^ (char_vec[0] == d_q);
            sh_q      <= char_vec >> 1;
            bits_q    <= char_last;
            div_q     <= '0;
            par_acc_q <= char_acc;
            state_q   <= S_SHIFT;
          end
        end
        default: begin
          if (div_q == DIV_LAST) begin
            if (bits_q == 4'd0) begin
              // Only reached when enable fell during the character.
              state_q <= S_IDLE;
              d_q     <= 1'b0;
              s_q     <= 1'b0;
            end else begin
              d_q    <= sh_q[0];
              s_q    <= s_q ^ (sh_q[0] == d_q);
              sh_q   <= sh_q >> 1;
              bits_q <= bits_q - 4'd1;
              div_q  <= '0;
              if (enable && (bits_q == 4'd1) && (G_CLK_DIV == 1)) state_q <= S_SELECT;
            end
          end else begin
            div_q <= div_inc;
            // SELECT occupies the last clk of the final bit so characters run back to back.
            if (enable && (bits_q == 4'd0) && (div_inc == DIV_LAST)) state_q <= S_SELECT;
          end
        end
      endcase
    end
  end

endmodule
